noc_flit_packetizer: RTL

- Injection-side network interface between a tile's message source and its Mesh22 router local port.
- Accepts one message per handshake: destination node, header field, 0..MAX_WORDS payload words.
- Serializes the message into 64-bit head/body/tail flits on a valid/ready link that drives the router's NodeN_data_in/valid_in/ready_in.
- Tags each packet with this node's source ID and counts completed packets.

---
 rtl/noc_pkg.sv | 56 +++++
 rtl/noc_flit_packetizer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/noc_pkg.sv
// noc_pkg
//   Shared definitions for the mesh network interfaces (packetizer on the
//   injection side, depacketizer on the ejection side).
//   - flit field widths and the flit type encoding
//   - packed layout of a head flit
//   - packetizer FSM state encoding
//   - make_head(): builds a head flit from its fields
package noc_pkg;

    localparam int FLIT_W    = 64;
    localparam int TYPE_W    = 2;
    localparam int NODE_ID_W = 2;
    localparam int LEN_W     = 3;
    localparam int HDR_W     = 55;
    localparam int PAYLOAD_W = 62;

    // Flit type lives in [63:62] of every flit.
    typedef enum logic [TYPE_W-1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    // Head flit: type | dest | src | len | hdr  (2+2+2+3+55 = 64 bits)
    typedef struct packed {
        flit_type_e           ftype;
        logic [NODE_ID_W-1:0] dest;
        logic [NODE_ID_W-1:0] src;
        logic [LEN_W-1:0]     len;
        logic [HDR_W-1:0]     hdr;
    } head_flit_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_HEAD = 2'd1,
        ST_SEND_BODY = 2'd2
    } pkt_state_e;

    // A zero-length packet is a single HEADTAIL flit.
    function automatic logic [FLIT_W-1:0] make_head(
        input logic [NODE_ID_W-1:0] dest,
        input logic [NODE_ID_W-1:0] src,
        input logic [LEN_W-1:0]     len,
        input logic [HDR_W-1:0]     hdr
    );
        head_flit_t h;
        h.ftype = (len == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
        h.dest  = dest;
        h.src   = src;
        h.len   = len;
        h.hdr   = hdr;
        return h;
    endfunction

endpackage

// File: rtl/noc_flit_packetizer.sv
// noc_flit_packetizer
//   Injection-side network interface. Accepts one message (dest, hdr,
//   0..MAX_WORDS payload words) per handshake and serializes it into
//   64-bit head/body/tail flits for the router local port. Counts
//   completed packets and flags over-length messages.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   msg_valid_i     message offered
//   msg_ready_o     message can be accepted (IDLE, or final flit leaving)
//   msg_dest_i      destination node ID
//   msg_len_i       payload word count (clamped to MAX_WORDS)
//   msg_hdr_i       header copied into the head flit
//   msg_data_i      payload, word k at [62k+61:62k]
//   flit_data_o     flit to router
//   flit_valid_o    flit valid
//   flit_ready_i    router accepts flit
//   pkt_count_o     completed packets, wraps at 2^16
//   len_err_o       sticky: a message had msg_len_i > MAX_WORDS
//
// Handshake (both sides): a transfer happens on a cycle with valid && ready.
// Once flit_valid_o rises, flit_data_o/flit_valid_o hold until accepted.
module noc_flit_packetizer
    import noc_pkg::*;
#(
    parameter int NODE_ID   = 0,
    parameter int MAX_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           msg_valid_i,
    output logic                           msg_ready_o,
    input  logic [NODE_ID_W-1:0]           msg_dest_i,
    input  logic [LEN_W-1:0]               msg_len_i,
    input  logic [HDR_W-1:0]               msg_hdr_i,
    input  logic [PAYLOAD_W*MAX_WORDS-1:0] msg_data_i,
    output logic [FLIT_W-1:0]              flit_data_o,
    output logic                           flit_valid_o,
    input  logic                           flit_ready_i,
    output logic [15:0]                    pkt_count_o,
    output logic                           len_err_o
);

    localparam logic [LEN_W-1:0]     MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic [NODE_ID_W-1:0] SRC_ID  = NODE_ID_W'(NODE_ID);

    pkt_state_e                     state_q, state_d;
    logic [LEN_W-1:0]               len_q;
    logic [LEN_W-1:0]               idx_q, idx_d;
    logic [PAYLOAD_W*MAX_WORDS-1:0] data_q;
    logic [FLIT_W-1:0]              flit_d;
    logic                           valid_d;

    logic                           accept;
    logic                           fire;
    logic                           last_flit;
    logic                           pkt_done;
    logic                           len_over;
    logic [LEN_W-1:0]               len_clamped;
    logic [LEN_W-1:0]               nxt_idx;
    logic [PAYLOAD_W-1:0]           nxt_word;
    flit_type_e                     nxt_type;

    always_comb begin
        fire        = flit_valid_o && flit_ready_i;
        // flit_data_o always holds the flit on the link, so its type field
        // tells us whether this transfer closes the packet.
        last_flit   = (flit_data_o[63:62] == FLIT_TAIL) ||
                      (flit_data_o[63:62] == FLIT_HEADTAIL);
        msg_ready_o = (state_q == ST_IDLE) || (fire && last_flit);
        accept      = msg_valid_i && msg_ready_o;
        len_over    = (msg_len_i > MAX_LEN);
        len_clamped = len_over ? MAX_LEN : msg_len_i;
    end

    // Next payload word to present: word 0 after the head, else idx_q+1.
    always_comb begin
        nxt_idx  = (state_q == ST_SEND_BODY) ? idx_q + 3'd1 : 3'd0;
        nxt_word = '0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (nxt_idx == LEN_W'(k)) begin
                nxt_word = data_q[k*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        nxt_type = (nxt_idx == len_q - 3'd1) ? FLIT_TAIL : FLIT_BODY;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        flit_d   = flit_data_o;
        valid_d  = flit_valid_o;
        pkt_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
            end
            ST_SEND_HEAD: begin
                if (fire) begin
                    if (len_q == '0) begin
                        pkt_done = 1'b1;
                    end else begin
                        state_d = ST_SEND_BODY;
                        idx_d   = nxt_idx;
                        flit_d  = {nxt_type, nxt_word};
                    end
                end
            end
            ST_SEND_BODY: begin
                if (fire) begin
                    if (idx_q == len_q - 3'd1) begin
                        pkt_done = 1'b1;
                    end else begin
                        idx_d  = nxt_idx;
                        flit_d = {nxt_type, nxt_word};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (pkt_done) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end

        // A new message can land in IDLE or in the cycle the last flit
        // leaves; either way its head goes out next cycle.
        if (accept) begin
            state_d = ST_SEND_HEAD;
            valid_d = 1'b1;
            idx_d   = '0;
            flit_d  = make_head(msg_dest_i, SRC_ID, len_clamped, msg_hdr_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            data_q       <= '0;
            flit_data_o  <= '0;
            flit_valid_o <= 1'b0;
            pkt_count_o  <= '0;
            len_err_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            flit_data_o  <= flit_d;
            flit_valid_o <= valid_d;
            if (accept) begin
                len_q  <= len_clamped;
                data_q <= msg_data_i;
                if (len_over) begin
                    len_err_o <= 1'b1;
                end
            end
            if (pkt_done) begin
                pkt_count_o <= pkt_count_o + 16'd1;
            end
        end
    end

endmodule
